// File: rtl/day_trading_advisor.sv
// -----------------------------------------------------------------------------
// day_trading_advisor
//
// Classifies the price trend in a packed market word and emits an action
// code through a three-stage registered pipeline (latency 3 edges,
// throughput one word per cycle).
//
// Ports:
//   clk        : single clock; every register updates on its rising edge
//   rst        : asynchronous active-high reset; clears all pipeline stages
//   stock_in   : [15] own, [14:10] p0 (oldest), [9:5] p1, [4:0] p2 (newest)
//   action_out : registered action code, bits [15:4] always zero
//
// Handshake: none. A word is sampled on every rising edge. The result
// appears on action_out after the second edge that follows the sampling
// edge. Reset drops every in-flight word.
//
// Optional feature (macro DAY_TRADING_STRONG_THRESH_EN):
//   defined   : a monotonic trend is strong only when |p2 - p0| >= STRONG_MIN.
//               A smaller swing is classed as weak in the same direction.
//   undefined : STRONG_MIN is ignored. Any monotonic trend with p2 != p0 is
//               strong.
// -----------------------------------------------------------------------------
module day_trading_advisor #(
  parameter int unsigned STRONG_MIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] stock_in,
  output logic [15:0] action_out
);

  // TREND_NONE marks an empty stage. An empty stage maps to action 0, so no
  // code leaks out before the first real word reaches the output.
  typedef enum logic [2:0] {
    TREND_NONE        = 3'd0,
    TREND_STAGNANT    = 3'd1,
    TREND_STRONG_UP   = 3'd2,
    TREND_STRONG_DOWN = 3'd3,
    TREND_WEAK_UP     = 3'd4,
    TREND_WEAK_DOWN   = 3'd5
  } trend_e;

  // ---------------------------------------------------------------------------
  // Stage 1: register the raw market word
  // ---------------------------------------------------------------------------
  logic [15:0] s1_word;
  logic        s1_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word <= 16'd0;
      s1_vld  <= 1'b0;
    end else begin
      s1_word <= stock_in;
      s1_vld  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Trend classification (combinational on the stage-1 word)
  // ---------------------------------------------------------------------------
  logic       s1_own;
  logic [4:0] p0;
  logic [4:0] p1;
  logic [4:0] p2;
  logic       mono_up;
  logic       mono_down;
  logic       strong_ok;
  trend_e     trend_next;

  assign s1_own = s1_word[15];
  assign p0     = s1_word[14:10];
  assign p1     = s1_word[9:5];
  assign p2     = s1_word[4:0];

  assign mono_up   = (p0 <= p1) && (p1 <= p2);
  assign mono_down = (p0 >= p1) && (p1 >= p2);

`ifdef DAY_TRADING_STRONG_THRESH_EN
  localparam logic [5:0] STRONG_MIN_W = 6'(STRONG_MIN);

  logic [5:0] swing;
  logic [5:0] swing_abs;

  // The swing is the net change in 6-bit two's complement. Its range is
  // -31..+31, so the magnitude always fits in 6 bits.
  assign swing     = {1'b0, p2} - {1'b0, p0};
  assign swing_abs = swing[5] ? (6'd0 - swing) : swing;
  assign strong_ok = (swing_abs >= STRONG_MIN_W);
`else
  assign strong_ok = 1'b1;
`endif

  always_comb begin
    trend_next = TREND_NONE;
    if (s1_vld) begin
      // The order of these tests sets priority: stagnant wins over monotonic.
      if (p2 == p0) begin
        trend_next = TREND_STAGNANT;
      end else if (p2 > p0) begin
        trend_next = (mono_up && strong_ok) ? TREND_STRONG_UP : TREND_WEAK_UP;
      end else begin
        trend_next = (mono_down && strong_ok) ? TREND_STRONG_DOWN : TREND_WEAK_DOWN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: register trend class and ownership
  // ---------------------------------------------------------------------------
  trend_e s2_trend;
  logic   s2_own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_trend <= TREND_NONE;
      s2_own   <= 1'b0;
    end else begin
      s2_trend <= trend_next;
      s2_own   <= s1_own;
    end
  end

  // ---------------------------------------------------------------------------
  // Action mapping (combinational on stage 2)
  // ---------------------------------------------------------------------------
  logic [3:0]  action_code;
  logic [15:0] action_next;

  always_comb begin
    action_code = 4'd0;
    case (s2_trend)
      TREND_STAGNANT:    action_code = s2_own ? 4'd8 : 4'd7;
      TREND_STRONG_UP:   action_code = s2_own ? 4'd1 : 4'd2;
      TREND_STRONG_DOWN: action_code = s2_own ? 4'd3 : 4'd4;
      TREND_WEAK_UP:     action_code = s2_own ? 4'd5 : 4'd6;
      TREND_WEAK_DOWN:   action_code = s2_own ? 4'd9 : 4'd10;
      default:           action_code = 4'd0;
    endcase
  end

  assign action_next = {12'd0, action_code};

  // ---------------------------------------------------------------------------
  // Stage 3: register the action code
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      action_out <= 16'd0;
    end else begin
      action_out <= action_next;
    end
  end

endmodule

// File: tb/tb_day_trading_advisor.sv
// -----------------------------------------------------------------------------
// tb_day_trading_advisor
//
// Directed-vector bench for day_trading_advisor. The driver changes
// stock_in on falling edges and queues the hand-computed action code for
// every cycle it drives. A monitor tracks which rising edges sampled a
// driven word, then pops and compares three edges later. It also checks
// that action_out is zero during reset and during the two edges after reset
// is released.
// -----------------------------------------------------------------------------
module tb_day_trading_advisor;

`ifdef DAY_TRADING_STRONG_THRESH_EN
  localparam int unsigned DUT_STRONG_MIN = 3;
  localparam logic [15:0] EXP_789_OUT    = 16'd6;  // swing 2 < 3 -> weak up
`else
  localparam int unsigned DUT_STRONG_MIN = 2;
  localparam logic [15:0] EXP_789_OUT    = 16'd2;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stock_in;
  logic [15:0] action_out;

  always #5 clk = ~clk;

  day_trading_advisor #(
    .STRONG_MIN (DUT_STRONG_MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stock_in   (stock_in),
    .action_out (action_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int          idx_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        drive_vld = 1'b0;
  logic [2:0]  tb_vld    = 3'b000;
  int          edges_since_rst = 0;
  int          vec_idx = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic own, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
    return {own, a, b, c};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [15:0] w, input logic [15:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      stock_in  = w;
      drive_vld = 1'b1;
      exp_q.push_back(e);
      idx_q.push_back(vec_idx);
      @(negedge clk);
    end
    vec_idx++;
  endtask

  task automatic apply_reset(input int n);
    rst       = 1'b1;
    drive_vld = 1'b0;
    exp_q.delete();
    idx_q.delete();
    #1;
    check("rst_async", action_out, 16'd0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (rst) begin
      tb_vld          = 3'b000;
      edges_since_rst = 0;
    end else begin
      tb_vld = {tb_vld[1:0], drive_vld};
      if (edges_since_rst < 100) edges_since_rst++;
    end
    #1;
    if (rst) begin
      check("rst_hold", action_out, 16'd0);
    end else if (tb_vld[2]) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 16'd1, 16'd0);
      end else begin
        check($sformatf("vec_%0d", idx_q.pop_front()), action_out, exp_q.pop_front());
      end
    end else if (edges_since_rst <= 2) begin
      check("rst_zero", action_out, 16'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    stock_in = 16'd0;
    #1;
    check("rst_init", action_out, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Stagnant, strong and weak trends held for several cycles
    drive(mk(1'b0, 5'd10, 5'd10, 5'd10), 16'd7, 6);
    drive(mk(1'b1, 5'd12, 5'd12, 5'd12), 16'd8, 4);
    drive(mk(1'b1, 5'd5,  5'd10, 5'd15), 16'd1, 4);
    drive(mk(1'b0, 5'd7,  5'd8,  5'd9),  EXP_789_OUT, 4);
    drive(mk(1'b0, 5'd5,  5'd10, 5'd15), 16'd2, 4);
    drive(mk(1'b0, 5'd20, 5'd15, 5'd10), 16'd4, 4);
    drive(mk(1'b1, 5'd18, 5'd10, 5'd5),  16'd3, 4);
    drive(mk(1'b1, 5'd10, 5'd12, 5'd8),  16'd9, 4);
    drive(mk(1'b0, 5'd10, 5'd12, 5'd8),  16'd10, 4);
    drive(mk(1'b1, 5'd10, 5'd7,  5'd14), 16'd5, 4);
    drive(mk(1'b0, 5'd5,  5'd3,  5'd10), 16'd6, 4);

    // Boundary values
    drive(mk(1'b0, 5'd0,  5'd0,  5'd0),  16'd7, 3);
    drive(mk(1'b1, 5'd0,  5'd15, 5'd31), 16'd1, 3);
    drive(mk(1'b0, 5'd31, 5'd0,  5'd0),  16'd4, 3);
    drive(mk(1'b1, 5'd4,  5'd20, 5'd4),  16'd8, 3);
    drive(mk(1'b0, 5'd31, 5'd31, 5'd0),  16'd4, 3);

    // Back-to-back distinct words, one cycle each
    drive(mk(1'b1, 5'd5,  5'd10, 5'd15), 16'd1, 1);
    drive(mk(1'b0, 5'd20, 5'd15, 5'd10), 16'd4, 1);
    drive(mk(1'b1, 5'd10, 5'd7,  5'd14), 16'd5, 1);
    drive(mk(1'b0, 5'd5,  5'd3,  5'd10), 16'd6, 1);
    drive(mk(1'b1, 5'd10, 5'd12, 5'd8),  16'd9, 1);

    // Reset mid-stream: in-flight words are discarded
    drive(mk(1'b1, 5'd12, 5'd12, 5'd12), 16'd8, 1);
    drive(mk(1'b0, 5'd10, 5'd12, 5'd8),  16'd10, 1);
    apply_reset(2);
    drive(mk(1'b1, 5'd18, 5'd10, 5'd5),  16'd3, 1);
    drive(mk(1'b0, 5'd10, 5'd10, 5'd10), 16'd7, 4);

    // Drain the pipeline, then confirm every queued expectation was consumed
    drive_vld = 1'b0;
    repeat (5) @(negedge clk);
    check("drain", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
